paddle_move_ctrl: RTL and testbench

Per-frame paddle position controller for the two-player pong display. It merges push-button and PS/2 keyboard requests for the left and right paddles, tracks held keys through a make/break scan-code FSM, and steps each paddle once per VGA frame. It sits between the PS/2 interface and the VGA controller, which draws both paddles from its position outputs.

---
 rtl/paddle_move_ctrl.sv | 132 +++++++++++++
 tb/tb_paddle_move_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/paddle_move_ctrl.sv
// Two-player pong paddle controller: merges PS/2 make/break key state with
// push buttons and steps each paddle once per VGA frame (falling iVS).
module paddle_move_ctrl #(
  parameter int SCREEN_H = 480,
  parameter int PADDLE_H = 80,
  parameter int STEP     = 4,
  parameter int INIT_Y   = 200
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iVS,
  input  logic       iKEY_pressed,
  input  logic [7:0] iKEY_data,
  input  logic       iBTN_L_up,
  input  logic       iBTN_L_dn,
  input  logic       iBTN_R_up,
  input  logic       iBTN_R_dn,
  output logic [9:0] oPL_Y,
  output logic [9:0] oPR_Y,
  output logic       oFRAME_TICK
);

  localparam logic [10:0] MAXY   = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  INIT_W = 10'(INIT_Y);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} scan_e;

  scan_e      scan_q, scan_d;
  logic       kl_up_q, kl_dn_q, kr_up_q, kr_dn_q;
  logic       kl_up_d, kl_dn_d, kr_up_d, kr_dn_d;
  // vs_q[1:0] is the synchronizer; vs_q[2] is last cycle's synchronized level
  logic [2:0] vs_q;
  logic [3:0] btn_s1_q, btn_s2_q;
  logic       fall_q, tick_q;
  logic [9:0] pl_y_q, pr_y_q;
  logic       up_l, dn_l, up_r, dn_r;

  function automatic logic [9:0] next_y(input logic [9:0] y, input logic up, input logic dn);
    logic [10:0] y_w;
    logic [9:0]  res;
    y_w = {1'b0, y};
    res = y;
    if (up && !dn)
      res = (y_w < STEP_W) ? 10'd0 : 10'(y_w - STEP_W);
    else if (dn && !up)
      res = (y_w + STEP_W > MAXY) ? MAXY[9:0] : 10'(y_w + STEP_W);
    return res;
  endfunction

  always_comb begin
    scan_d  = scan_q;
    kl_up_d = kl_up_q;
    kl_dn_d = kl_dn_q;
    kr_up_d = kr_up_q;
    kr_dn_d = kr_dn_q;
    if (iKEY_pressed) begin
      scan_d = S_IDLE;
      case (scan_q)
        S_IDLE: begin
          if (iKEY_data == 8'hE0)      scan_d  = S_EXT;
          else if (iKEY_data == 8'hF0) scan_d  = S_BRK;
          else if (iKEY_data == 8'h1D) kl_up_d = 1'b1;
          else if (iKEY_data == 8'h1B) kl_dn_d = 1'b1;
        end
        S_EXT: begin
          if (iKEY_data == 8'hF0)      scan_d  = S_EXT_BRK;
          else if (iKEY_data == 8'h75) kr_up_d = 1'b1;
          else if (iKEY_data == 8'h72) kr_dn_d = 1'b1;
        end
        S_BRK: begin
          if (iKEY_data == 8'h1D)      kl_up_d = 1'b0;
          else if (iKEY_data == 8'h1B) kl_dn_d = 1'b0;
        end
        S_EXT_BRK: begin
          if (iKEY_data == 8'h75)      kr_up_d = 1'b0;
          else if (iKEY_data == 8'h72) kr_dn_d = 1'b0;
        end
        default: scan_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      scan_q  <= S_IDLE;
      kl_up_q <= 1'b0;
      kl_dn_q <= 1'b0;
      kr_up_q <= 1'b0;
      kr_dn_q <= 1'b0;
    end else begin
      scan_q  <= scan_d;
      kl_up_q <= kl_up_d;
      kl_dn_q <= kl_dn_d;
      kr_up_q <= kr_up_d;
      kr_dn_q <= kr_dn_d;
    end
  end

  // buttons are active-low; btn_s2_q bit order {R_dn, R_up, L_dn, L_up}
  assign up_l = kl_up_q | ~btn_s2_q[0];
  assign dn_l = kl_dn_q | ~btn_s2_q[1];
  assign up_r = kr_up_q | ~btn_s2_q[2];
  assign dn_r = kr_dn_q | ~btn_s2_q[3];

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q     <= 3'b111;
      btn_s1_q <= 4'hF;
      btn_s2_q <= 4'hF;
      fall_q   <= 1'b0;
      tick_q   <= 1'b0;
      pl_y_q   <= INIT_W;
      pr_y_q   <= INIT_W;
    end else begin
      vs_q     <= {vs_q[1], vs_q[0], iVS};
      btn_s1_q <= {iBTN_R_dn, iBTN_R_up, iBTN_L_dn, iBTN_L_up};
      btn_s2_q <= btn_s1_q;
      fall_q   <= vs_q[2] & ~vs_q[1];
      tick_q   <= fall_q;
      if (fall_q) begin
        pl_y_q <= next_y(pl_y_q, up_l, dn_l);
        pr_y_q <= next_y(pr_y_q, up_r, dn_r);
      end
    end
  end

  assign oPL_Y       = pl_y_q;
  assign oPR_Y       = pr_y_q;
  assign oFRAME_TICK = tick_q;

endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Randomized bench for paddle_move_ctrl: a history-based model predicts every
// cycle's paddle positions and frame tick from the driven inputs.
module tb_paddle_move_ctrl;
  localparam int MAXY = 400, STEP = 4, INIT = 200, NCYC = 20000;

  logic       iCLK = 0, iRST_n = 0, iVS = 1, iKEY_pressed = 0;
  logic [7:0] iKEY_data = 0;
  logic       iBTN_L_up = 1, iBTN_L_dn = 1, iBTN_R_up = 1, iBTN_R_dn = 1;
  logic [9:0] oPL_Y, oPR_Y;
  logic       oFRAME_TICK;

  paddle_move_ctrl dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iVS(iVS), .iKEY_pressed(iKEY_pressed),
    .iKEY_data(iKEY_data), .iBTN_L_up(iBTN_L_up), .iBTN_L_dn(iBTN_L_dn),
    .iBTN_R_up(iBTN_R_up), .iBTN_R_dn(iBTN_R_dn), .oPL_Y(oPL_Y), .oPR_Y(oPR_Y),
    .oFRAME_TICK(oFRAME_TICK));

  always #10 iCLK = ~iCLK;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // driven-input history, indexed by the cycle in which the value was driven
  logic       vs_h [NCYC];
  logic [3:0] btn_h [NCYC];   // press bits {R_dn,R_up,L_dn,L_up}, 1 = pressed
  logic       kp_h [NCYC];
  logic [7:0] kd_h [NCYC];
  int cyc = 0, rst_rel = 0, rst_cnt = 0;
  bit in_rst = 1;

  // reference state
  int  yl, yr, ticks_exp = 0, ticks_obs = 0;
  bit  t_exp;
  bit  kl_up, kl_dn, kr_up, kr_dn, pend_e0, pend_f0;

  function automatic logic vs_at(input int j);
    return (j < rst_rel) ? 1'b1 : vs_h[j];
  endfunction
  function automatic logic [3:0] btn_at(input int j);
    return (j < rst_rel) ? 4'h0 : btn_h[j];
  endfunction

  task automatic model_reset();
    yl = INIT; yr = INIT; t_exp = 0;
    {kl_up, kl_dn, kr_up, kr_dn, pend_e0, pend_f0} = '0;
  endtask

  function automatic int move(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - STEP < 0) ? 0 : y - STEP;
    if (dn && !up) return (y + STEP > MAXY) ? MAXY : y + STEP;
    return y;
  endfunction

  task automatic decode(input logic [7:0] b);
    if (!pend_e0 && !pend_f0) begin
      if (b == 8'hE0) pend_e0 = 1;
      else if (b == 8'hF0) pend_f0 = 1;
      else if (b == 8'h1D) kl_up = 1;
      else if (b == 8'h1B) kl_dn = 1;
    end else if (pend_e0 && !pend_f0) begin
      pend_e0 = 0;
      if (b == 8'hF0) begin pend_e0 = 1; pend_f0 = 1; end
      else if (b == 8'h75) kr_up = 1;
      else if (b == 8'h72) kr_dn = 1;
    end else if (!pend_e0) begin
      pend_f0 = 0;
      if (b == 8'h1D) kl_up = 0;
      else if (b == 8'h1B) kl_dn = 0;
    end else begin
      pend_e0 = 0; pend_f0 = 0;
      if (b == 8'h75) kr_up = 0;
      else if (b == 8'h72) kr_dn = 0;
    end
  endtask

  // model of one active clock edge: step with the flags in force before the edge
  task automatic model_edge(input int m);
    logic [3:0] b;
    t_exp = 0;
    if (in_rst) return;
    if (m >= 5 && vs_at(m-4) == 1'b0 && vs_at(m-5) == 1'b1) begin
      b = btn_at(m-3);
      yl = move(yl, kl_up | b[0], kl_dn | b[1]);
      yr = move(yr, kr_up | b[2], kr_dn | b[3]);
      t_exp = 1;
      ticks_exp++;
    end
    if (m >= 1 && m-1 >= rst_rel && kp_h[m-1]) decode(kd_h[m-1]);
  endtask

  // stimulus generator state
  logic [7:0] kq[$];
  logic [3:0] btn_press = 0;
  int fc = 0, period = 12, frames = 0, kgap = 0;

  task automatic cycle1();
    @(posedge iCLK);
    cyc++;
    model_edge(cyc);
    #1;
    if (rst_cnt > 0) begin
      iRST_n = 0; in_rst = 1; rst_cnt--; model_reset();
    end else if (in_rst) begin
      iRST_n = 1; in_rst = 0; rst_rel = cyc;
    end
    iVS = (fc < 3) ? 1'b0 : 1'b1;
    if (++fc >= period) begin fc = 0; frames++; period = $urandom_range(5, 20); end
    iKEY_pressed = 0;
    iKEY_data = 8'($urandom);
    if (kgap > 0) kgap--;
    else if (!in_rst && kq.size() > 0) begin
      iKEY_pressed = 1; iKEY_data = kq.pop_front(); kgap = $urandom_range(0, 3);
    end
    {iBTN_R_dn, iBTN_R_up, iBTN_L_dn, iBTN_L_up} = ~btn_press;
    vs_h[cyc] = iVS; btn_h[cyc] = btn_press; kp_h[cyc] = iKEY_pressed; kd_h[cyc] = iKEY_data;
    @(negedge iCLK);
    if (oFRAME_TICK === 1'b1) ticks_obs++;
    chk("pl_y", 16'(oPL_Y), 16'(yl));
    chk("pr_y", 16'(oPR_Y), 16'(yr));
    chk("tick", 16'(oFRAME_TICK), 16'(t_exp));
  endtask

  task automatic run_frames(input int n);
    int target, budget;
    target = frames + n; budget = n * 25 + 60;
    while (frames < target && budget > 0) begin cycle1(); budget--; end
    if (frames < target) chk("frame_timeout", 16'(frames), 16'(target));
    for (int i = 0; i < 6; i++) cycle1();   // let the last step and queued keys land
  endtask

  task automatic send(input logic [7:0] b);
    kq.push_back(b);
  endtask

  localparam int NKEYS = 8;
  logic [7:0] keyset [NKEYS] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'h29, 8'h1C};

  initial begin
    model_reset();
    rst_cnt = 3;
    for (int i = 0; i < 4; i++) cycle1();
    chk("rst_pl_y", 16'(oPL_Y), 16'(INIT));
    chk("rst_tick", 16'(oFRAME_TICK), 16'd0);

    run_frames(3);
    chk("idle_ticks", 16'(ticks_obs), 16'(ticks_exp));
    chk("idle_pl_y", 16'(oPL_Y), 16'(INIT));

    send(8'h1D); run_frames(10);
    send(8'hF0); send(8'h1D); run_frames(2);
    send(8'hE0); send(8'h72); run_frames(60);
    chk("pr_sat", 16'(oPR_Y), 16'(MAXY));
    send(8'hE0); send(8'hF0); send(8'h72); run_frames(2);
    btn_press = 4'b0001; run_frames(55);
    chk("pl_clamp", 16'(oPL_Y), 16'd0);
    btn_press = 4'b0011; run_frames(3);
    btn_press = 4'b0010; run_frames(4);
    btn_press = 4'b0000; run_frames(1);

    for (int s = 0; s < 25; s++) begin
      int nb;
      nb = $urandom_range(0, 4);
      for (int k = 0; k < nb; k++) send(keyset[$urandom_range(0, NKEYS-1)]);
      btn_press = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      run_frames($urandom_range(1, 15));
    end

    // reset between an extended prefix and its key byte
    btn_press = 0; send(8'hE0);
    for (int i = 0; i < 8; i++) cycle1();
    rst_cnt = 2;
    for (int i = 0; i < 3; i++) cycle1();
    chk("midrst_pr_y", 16'(oPR_Y), 16'(INIT));
    send(8'h75); run_frames(2);
    chk("no_ext_after_rst", 16'(oPR_Y), 16'(INIT));
    send(8'h1B); run_frames(3);
    chk("kl_dn_after_rst", 16'(oPL_Y), 16'(yl));
    chk("total_ticks", 16'(ticks_obs), 16'(ticks_exp));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
